// File: rtl/eth_pcs_tx_scrambler_pkg.sv
// eth_pcs_params: shared widths, scrambler taps and idle-block constants for the PCS TX scrambler
package eth_pcs_params;
  localparam int W_BLK = 64;
  localparam int W_SYNC = 2;
  localparam int W_DATA = 32;
  localparam int N_TRANS = W_BLK / W_DATA;
  localparam int W_TRANS_PER_BLK = $clog2(N_TRANS);
  localparam int W_SCR_STATE = 58;
  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;
  localparam int W_UFLOW_CNT = 16;
  localparam logic [W_SYNC-1:0] IDLE_SYNC = 2'b10;
  localparam logic [W_BLK-1:0] IDLE_BLK = 64'h0000_0000_0000_001E;
  typedef struct packed {
    logic [W_SYNC-1:0] sync;
    logic [W_BLK-1:0] data;
  } blk_t;
  localparam blk_t IDLE = '{sync: IDLE_SYNC, data: IDLE_BLK};
endpackage

// File: rtl/eth_pcs_tx_scrambler_if.sv
// eth_pcs_tx_scrambler_if: encoder-to-scrambler 66b block handshake
// master drives blk_valid/sync_hdr/blk_data, slave returns blk_ready
interface eth_pcs_tx_scrambler_if;
  import eth_pcs_params::*;
  logic blk_valid;
  logic [W_SYNC-1:0] sync_hdr;
  logic [W_BLK-1:0] blk_data;
  logic blk_ready;
  modport master(output blk_valid, sync_hdr, blk_data, input blk_ready);
  modport slave(input blk_valid, sync_hdr, blk_data, output blk_ready);
endinterface

// File: rtl/eth_pcs_tx_scrambler_scr_core.sv
// eth_pcs_scr_core: one 32-bit parallel step of the 1+x^39+x^58 self-synchronous scrambler
// i_state: scrambled history (MSB newest), i_data: word (bit 0 first), o_data: scrambled word, o_state: advanced history
module eth_pcs_scr_core
  import eth_pcs_params::*;
(
  input  logic [W_SCR_STATE-1:0] i_state,
  input  logic [W_DATA-1:0]      i_data,
  output logic [W_DATA-1:0]      o_data,
  output logic [W_SCR_STATE-1:0] o_state
);
  // the word is shorter than the nearest tap, so every tap reads old history and there is no intra-word feedback
  assign o_data = i_data ^ i_state[SCR_TAP_B-SCR_TAP_A +: W_DATA] ^ i_state[W_DATA-1:0];
  assign o_state = {o_data, i_state[W_SCR_STATE-1:W_DATA]};
endmodule

// File: rtl/eth_pcs_tx_scrambler.sv
// eth_pcs_tx_scrambler: one-block buffer feeding a 64b/66b TX scrambler in 32-bit gearbox transfers, idle substitution on underflow
// ports: i_clk, i_reset (sync, active-high), i_blk (block handshake, slave), i_clk_en/i_trans_cnt (gearbox transfer strobe/index),
//        o_sync_hdr/o_scr_data (current transfer), o_underflow (idle substituted), o_uflow_cnt (saturating substitution count)
// option: ETH_PCS_TX_SCR_BYPASS_EN adds i_scr_bypass, which sends the payload unscrambled while history still advances
module eth_pcs_tx_scrambler
  import eth_pcs_params::*;
#(
  parameter logic [W_SCR_STATE-1:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  eth_pcs_tx_scrambler_if.slave      i_blk,
  input  logic                       i_clk_en,
  input  logic [W_TRANS_PER_BLK-1:0] i_trans_cnt,
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
  input  logic                       i_scr_bypass,
`endif
  output logic [W_SYNC-1:0]          o_sync_hdr,
  output logic [W_DATA-1:0]          o_scr_data,
  output logic                       o_underflow,
  output logic [W_UFLOW_CNT-1:0]     o_uflow_cnt
);
  logic [W_SCR_STATE-1:0] r_scr;
  blk_t r_buf;
  logic r_full, r_subst;
  logic w_first, w_last, w_acc, w_cons, w_idle_sel;
  blk_t w_blk;
  logic [W_DATA-1:0] w_word, w_core_data;
  logic [W_SCR_STATE-1:0] w_state, w_core_next, w_next;
  assign w_first = i_clk_en & (i_trans_cnt == '0);
  assign w_last = i_clk_en & (i_trans_cnt == W_TRANS_PER_BLK'(N_TRANS - 1));
  assign i_blk.blk_ready = i_reset | ~r_full | (w_last & ~r_subst);
  assign w_acc = i_blk.blk_valid & i_blk.blk_ready & ~i_reset;
  assign w_cons = w_last & ~r_subst & r_full;
  assign o_underflow = w_first & ~r_full & ~i_reset;
  // an empty buffer always shows idle, so the substitution is visible in the very cycle it is decided
  assign w_idle_sel = i_reset | r_subst | ~r_full;
  assign w_blk = w_idle_sel ? IDLE : r_buf;
  // reset shows the seeded idle block even before the seed has been clocked in
  assign w_state = i_reset ? SCR_SEED : r_scr;
  assign w_word = w_blk.data[i_trans_cnt*W_DATA +: W_DATA];
  assign o_sync_hdr = w_blk.sync;
  eth_pcs_scr_core u_core (
    .i_state(w_state),
    .i_data (w_word),
    .o_data (w_core_data),
    .o_state(w_core_next)
  );
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
  assign o_scr_data = i_scr_bypass ? w_word : w_core_data;
  assign w_next = i_scr_bypass ? {w_word, w_state[W_SCR_STATE-1:W_DATA]} : w_core_next;
`else
  assign o_scr_data = w_core_data;
  assign w_next = w_core_next;
`endif
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scr <= SCR_SEED;
      r_full <= 1'b0;
      r_subst <= 1'b0;
      o_uflow_cnt <= '0;
    end else begin
      if (i_clk_en) r_scr <= w_next;
      if (w_acc) begin
        r_buf <= {i_blk.sync_hdr, i_blk.blk_data};
        r_full <= 1'b1;
      end else if (w_cons) r_full <= 1'b0;
      r_subst <= o_underflow ? 1'b1 : w_last ? 1'b0 : r_subst;
      if (o_underflow & ~&o_uflow_cnt) o_uflow_cnt <= o_uflow_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_eth_pcs_tx_scrambler.sv
// tb_eth_pcs_tx_scrambler: vector table, directed corner sequences and randomized traffic against a bit-serial reference
module tb_eth_pcs_tx_scrambler;
  import eth_pcs_params::*;
  logic clk = 0, rst = 1, en = 0;
  logic [W_TRANS_PER_BLK-1:0] tc = '0;
  logic [W_SYNC-1:0] o_sync;
  logic [W_DATA-1:0] o_data;
  logic o_uf;
  logic [W_UFLOW_CNT-1:0] o_cnt;
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
  logic byp = 0;
`endif
  eth_pcs_tx_scrambler_if bif ();
  eth_pcs_tx_scrambler dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_blk(bif),
    .i_clk_en(en),
    .i_trans_cnt(tc),
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
    .i_scr_bypass(byp),
`endif
    .o_sync_hdr(o_sync),
    .o_scr_data(o_data),
    .o_underflow(o_uf),
    .o_uflow_cnt(o_cnt)
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0;
  bit hist[$];
  typedef struct {
    logic [1:0] sync;
    logic [63:0] data;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  vec_t tv[4];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] s, input logic [63:0] d, input logic e, input logic [W_TRANS_PER_BLK-1:0] t);
    bif.blk_valid = v;
    bif.sync_hdr = s;
    bif.blk_data = d;
    en = e;
    tc = t;
    #1;
  endtask
  task automatic do_reset;
    rst = 1;
    drive(0, 2'b00, 64'h0, 0, 0);
    tick;
    rst = 0;
  endtask
  function automatic void m_seed;
    hist.delete();
    for (int i = 0; i < W_SCR_STATE; i++) hist.push_back(1'b1);
  endfunction
  // out[n] = d[n] ^ s[n-39] ^ s[n-58], one bit at a time, history holds the last 58 sent bits
  function automatic logic [31:0] m_scr(input logic [31:0] d, input bit b);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = d[i] ^ (b ? 1'b0 : (hist[hist.size()-SCR_TAP_A] ^ hist[hist.size()-SCR_TAP_B]));
      hist.push_back(r[i]);
      void'(hist.pop_front());
    end
    return r;
  endfunction
  initial begin
    logic [63:0] idle, a, b, c, d;
    logic [31:0] e;
    logic [65:0] mcur, mbuf;
    logic mf, mci, v, ee, er;
    logic [1:0] s;
    logic [W_TRANS_PER_BLK-1:0] t;
    int mcnt;
    idle = 64'h0000_0000_0000_001E;
    a = 64'h1122_3344_5566_7788;
    b = 64'hA5A5_0F0F_C3C3_9696;
    c = 64'hFFFF_0000_FFFF_0000;
    tv[0] = '{2'b01, 64'h0, 32'h0000_0000, 32'h03FF_FF80};
    tv[1] = '{2'b10, 64'hDEAD_BEEF_0123_4567, 32'h0123_4567, 32'h0};
    tv[2] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    tv[3] = '{2'b10, 64'h0000_0000_0000_001E, 32'h0000_001E, 32'h0};
    for (int i = 1; i < 4; i++) begin
      m_seed();
      void'(m_scr(tv[i].data[31:0], 0));
      tv[i].e1 = m_scr(tv[i].data[63:32], 0);
    end
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
    byp = 0;
`endif
    for (int i = 0; i < 4; i++) begin
      do_reset();
      chk($sformatf("vec%0d_rst_ready", i), bif.blk_ready, 1);
      chk($sformatf("vec%0d_rst_cnt", i), o_cnt, 0);
      drive(1, tv[i].sync, tv[i].data, 0, 0);
      tick;
      drive(0, 2'b00, 64'h0, 1, 0);
      chk($sformatf("vec%0d_sync", i), o_sync, tv[i].sync);
      chk($sformatf("vec%0d_t0", i), o_data, tv[i].e0);
      chk($sformatf("vec%0d_uf", i), o_uf, 0);
      tick;
      drive(0, 2'b00, 64'h0, 1, 1);
      chk($sformatf("vec%0d_t1", i), o_data, tv[i].e1);
      tick;
    end
    do_reset();
    drive(1, tv[1].sync, tv[1].data, 0, 0);
    tick;
    drive(0, 2'b00, 64'h0, 1, 0);
    chk("stall_t0", o_data, tv[1].e0);
    tick;
    for (int k = 0; k < 3; k++) begin
      drive(0, 2'b00, 64'h0, 0, 1);
      chk("stall_hold", o_data, tv[1].e1);
      tick;
    end
    drive(0, 2'b00, 64'h0, 1, 1);
    chk("stall_t1", o_data, tv[1].e1);
    tick;
    m_seed();
    void'(m_scr(tv[1].data[31:0], 0));
    void'(m_scr(tv[1].data[63:32], 0));
    drive(0, 2'b00, 64'h0, 1, 0);
    chk("stall_next_t0", o_data, m_scr(idle[31:0], 0));
    chk("stall_next_uf", o_uf, 1);
    tick;
    do_reset();
    m_seed();
    drive(0, 2'b00, 64'h0, 1, 0);
    chk("uf_sync", o_sync, 2'b10);
    chk("uf_t0", o_data, 32'h0000_001E);
    void'(m_scr(idle[31:0], 0));
    chk("uf_pulse", o_uf, 1);
    tick;
    chk("uf_cnt", o_cnt, 1);
    drive(1, 2'b01, a, 1, 1);
    chk("uf_ready_t1", bif.blk_ready, 1);
    chk("uf_no_pulse_t1", o_uf, 0);
    chk("uf_t1", o_data, m_scr(idle[63:32], 0));
    tick;
    drive(0, 2'b00, 64'h0, 0, 0);
    chk("held_ready", bif.blk_ready, 0);
    tick;
    drive(0, 2'b00, 64'h0, 1, 0);
    chk("held_sync", o_sync, 2'b01);
    chk("held_t0", o_data, m_scr(a[31:0], 0));
    chk("held_uf", o_uf, 0);
    tick;
    drive(1, 2'b01, b, 1, 1);
    chk("b2b_ready", bif.blk_ready, 1);
    chk("held_t1", o_data, m_scr(a[63:32], 0));
    tick;
    drive(0, 2'b00, 64'h0, 1, 0);
    chk("b2b_sync", o_sync, 2'b01);
    chk("b2b_t0", o_data, m_scr(b[31:0], 0));
    chk("b2b_no_uf", o_uf, 0);
    tick;
    chk("b2b_cnt", o_cnt, 1);
    rst = 1;
    drive(1, 2'b01, c, 1, 0);
    chk("in_rst_sync", o_sync, 2'b10);
    chk("in_rst_t0", o_data, 32'h0000_001E);
    chk("in_rst_uf", o_uf, 0);
    drive(1, 2'b01, c, 0, 1);
    m_seed();
    e = m_scr(idle[63:32], 0);
    chk("rst_mid_t1", o_data, e);
    chk("rst_mid_ready", bif.blk_ready, 1);
    tick;
    rst = 0;
    drive(0, 2'b00, 64'h0, 1, 1);
    chk("post_rst_t1", o_data, e);
    chk("post_rst_cnt", o_cnt, 0);
    chk("post_rst_ready", bif.blk_ready, 1);
    tick;
    drive(0, 2'b00, 64'h0, 1, 0);
    chk("post_rst_uf", o_uf, 1);
    chk("post_rst_t0", o_data, m_scr(idle[31:0], 0));
    tick;
`ifdef ETH_PCS_TX_SCR_BYPASS_EN
    do_reset();
    byp = 1;
    d = 64'hDEAD_BEEF_0123_4567;
    drive(1, 2'b01, d, 0, 0);
    tick;
    drive(0, 2'b00, 64'h0, 1, 0);
    chk("byp_t0", o_data, 32'h0123_4567);
    tick;
    drive(0, 2'b00, 64'h0, 1, 1);
    chk("byp_t1", o_data, 32'hDEAD_BEEF);
    tick;
    byp = 0;
    m_seed();
    void'(m_scr(d[31:0], 1));
    void'(m_scr(d[63:32], 1));
    drive(0, 2'b00, 64'h0, 1, 0);
    chk("byp_after_t0", o_data, m_scr(idle[31:0], 0));
    tick;
`endif
    do_reset();
    m_seed();
    mf = 0;
    mci = 0;
    mcnt = 0;
    t = '0;
    mbuf = '0;
    mcur = '0;
    for (int n = 0; n < 4000; n++) begin
      ee = ($urandom_range(0, 3) != 0);
      v = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      d = {$urandom, $urandom};
      drive(v, s, d, ee, t);
      er = ~mf | (ee & (t == 1) & ~mci);
      chk("rnd_ready", bif.blk_ready, er);
      chk("rnd_uf", o_uf, ee & (t == 0) & ~mf);
      if (ee) begin
        if (t == 0) begin
          mcur = mf ? mbuf : {2'b10, idle};
          mci = ~mf;
          if (!mf && mcnt != 65535) mcnt++;
          chk("rnd_sync", o_sync, mcur[65:64]);
        end
        chk("rnd_data", o_data, m_scr((t == 0) ? mcur[31:0] : mcur[63:32], 0));
        if (t == 1) begin
          if (!mci) mf = 0;
          mci = 0;
        end
      end
      if (v & er) begin
        mf = 1;
        mbuf = {s, d};
      end
      if (ee) t = ~t;
      tick;
    end
    chk("rnd_cnt", o_cnt, 64'(mcnt));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_pcs_tx_scrambler.md
ETH_PCS_TX_SCRAMBLER -- requirements
Module: eth_pcs_tx_scrambler

Interface
REQ-001 The block SHALL have parameter SCR_SEED, default 58'h3FF_FFFF_FFFF_FFFF, which is the scrambler state loaded at reset.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_reset  input  1  reset; synchronous, active-high.
REQ-004 i_blk_valid  input  1  encoder presents a 66b block.
REQ-005 i_sync_hdr  input  W_SYNC  sync header of the presented block; never scrambled.
REQ-006 i_blk_data  input  W_BLK (64)  block payload; bit 0 is sent first.
REQ-007 o_blk_ready  output  1  block accepted when i_blk_valid & o_blk_ready.
REQ-008 i_clk_en  input  1  gearbox transfer strobe; outputs are consumed in this cycle.
REQ-009 i_trans_cnt  input  W_TRANS_PER_BLK  gearbox transfer index within a block (0 = first).
REQ-010 o_sync_hdr  output  W_SYNC  header of the current block; meaningful when i_trans_cnt==0.
REQ-011 o_scr_data  output  W_DATA (32)  scrambled transfer i_trans_cnt.
REQ-012 o_underflow  output  1  single-cycle pulse when an idle block is substituted.
REQ-013 o_uflow_cnt  output  W_UFLOW_CNT (16)  saturating count of substituted blocks.

Function
REQ-014 The block SHALL hold exactly one 66b block in a buffer register, with a full flag.
REQ-015 o_blk_ready SHALL equal ~full | (i_clk_en & i_trans_cnt==last transfer & ~subst), so a block can be accepted and consumed in the same cycle.
REQ-016 Transfer k SHALL carry payload bits [32k+31:32k] of the active block.
REQ-017 o_scr_data and o_sync_hdr SHALL be combinational functions of registered state only; there SHALL be no combinational path from i_blk_* to the outputs, and latency is one cycle from acceptance to the earliest transfer 0.
REQ-018 Scrambling SHALL use the polynomial 1+x^39+x^58: out[n] = d[n] ^ s[n-39] ^ s[n-58], where s is the scrambled output history and bit 0 is processed first.
REQ-019 The 58-bit state SHALL advance by 32 bits only in cycles with i_clk_en=1; with i_clk_en=0 the state, buffer and outputs SHALL hold.
REQ-020 If i_clk_en=1, i_trans_cnt==0 and the buffer is empty, the block SHALL set subst for the whole block and output the idle block (sync 2'b10, payload 64'h0000_0000_0000_001E), scrambled normally.
REQ-021 In the same underflow cycle the block SHALL pulse o_underflow and increment o_uflow_cnt, saturating at all-ones.
REQ-022 A block accepted while subst=1 SHALL wait and be used first at the next transfer 0.
REQ-023 subst SHALL clear on the last transfer with i_clk_en=1.
REQ-024 The full flag SHALL clear on the consumed last transfer unless a new block is accepted in the same cycle.

Reset
REQ-025 When i_reset=1 the block SHALL set: state=SCR_SEED, full=0, subst=0, o_uflow_cnt=0, o_underflow=0, o_blk_ready=1.
REQ-026 While in reset, o_scr_data and o_sync_hdr SHALL be the scrambled idle block (REQ-020) for transfer i_trans_cnt.
REQ-027 A reset asserted mid-block SHALL discard the buffered block; i_blk_valid is ignored during reset.

Configuration
REQ-028 With ETH_PCS_TX_SCR_BYPASS_EN defined, the block SHALL add input i_scr_bypass (1 bit); when it is 1, o_scr_data is the unscrambled payload and the state still advances using the unscrambled data.
REQ-029 Without ETH_PCS_TX_SCR_BYPASS_EN, the port SHALL be absent and scrambling is always on.

Structure
REQ-030 The following constants SHALL be placed in eth_pcs_params: W_BLK, W_SCR_STATE=58, SCR_TAP_A=39, SCR_TAP_B=58, W_UFLOW_CNT, IDLE_SYNC, IDLE_BLK.
REQ-031 A combinational sub-module eth_pcs_scr_core SHALL implement the 32-bit parallel scrambler step (inputs: state, data; outputs: scrambled data, next state).

Verification
REQ-032 After reset (seed all-ones), feed one zero-payload block with sync 2'b01 → transfer 0: o_sync_hdr=2'b01, o_scr_data=32'h0000_0000; transfer 1: o_scr_data=32'h03FF_FF80.
REQ-033 Hold i_clk_en=0 for 3 cycles between transfers → o_scr_data stable and the next transfer is identical to the same scenario run without the stall.
REQ-034 Leave the buffer empty at transfer 0 → o_sync_hdr=2'b10, o_underflow pulses once, o_uflow_cnt=1; a block offered at transfer 1 is held and appears at the next transfer 0.
REQ-035 Buffer full and i_blk_valid=1 on the last transfer with i_clk_en=1 → o_blk_ready=1, back-to-back blocks, no underflow.
REQ-036 Assert i_reset after transfer 0 → transfer 1 output equals the seeded idle block, o_uflow_cnt=0, o_blk_ready=1.
REQ-037 With bypass defined and i_scr_bypass=1, payload 64'hDEAD_BEEF_0123_4567 → transfer 0 = 32'h0123_4567, transfer 1 = 32'hDEAD_BEEF.
